// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the show-ahead FIFO burst reader.
package fifo_rd_pkg;
  localparam int BUF_DEPTH = 3;

  typedef logic [1:0] ptr_t;
  typedef logic [1:0] cnt_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/fifo_rd_skid3.sv
// 3-entry circular holding buffer of {data, last}; head entry's last flag can be forced.
module fifo_rd_skid3 import fifo_rd_pkg::*; #(
  parameter int DW = 16
) (
  input  logic          rd_clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  input  logic          set_head_last,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output cnt_t          cnt
);
  logic [DW-1:0]        data_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] last_q, last_d;
  ptr_t                 head_q, head_d, tail_q, tail_d;
  cnt_t                 cnt_q, cnt_d;

  always_comb begin
    head_d = pop  ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    last_d = last_q;
    if (set_head_last) last_d[head_q] = 1'b1;
    if (push)          last_d[tail_q] = push_last;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  // Payload is qualified by cnt/last, so it needs no reset.
  always_ff @(posedge rd_clk) begin
    if (push) data_q[tail_q] <= push_data;
  end

  assign head_data = data_q[head_q];
  assign head_last = last_q[head_q];
  assign cnt       = cnt_q;
endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a show-ahead FIFO into a valid/ready stream framed in bursts closed by count or idle timeout.
module fifo_burst_reader import fifo_rd_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);
  localparam int BW = clog2(BURST_LEN);
  localparam int TW = clog2(TIMEOUT + 1);

  cnt_t                  cnt;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  hs, burst_end, tmr_run, tmr_exp;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]         timer_q, timer_d;

  // Pop decision looks only at the FIFO flag and local flops, never at m_ready.
  assign fifo_rd_en = rst_n & ~fifo_empty & (cnt != 2'd3);

  // The newest beat of an open burst stays hidden until it is known whether it is last.
  assign m_valid = (cnt >= 2'd2) | ((cnt != 2'd0) & head_last);
  assign m_data  = head_data;
  assign m_last  = head_last & m_valid;
  assign hs      = m_valid & m_ready;
  assign busy    = (cnt != 2'd0) | (beat_cnt_q != '0);

  assign burst_end = (beat_cnt_q == BW'(BURST_LEN - 1));
  assign tmr_run   = (cnt == 2'd1) & ~head_last & ~fifo_rd_en;
  assign tmr_exp   = tmr_run & (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    timer_d    = '0;
    if (fifo_rd_en)   beat_cnt_d = burst_end ? '0 : beat_cnt_q + 1'b1;
    else if (tmr_exp) beat_cnt_d = '0;
    if (tmr_run && !tmr_exp) timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      timer_q    <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      timer_q    <= timer_d;
    end
  end

  fifo_rd_skid3 #(.DW(DATA_WIDTH)) u_skid (
    .rd_clk        (rd_clk),
    .rst_n         (rst_n),
    .push          (fifo_rd_en),
    .push_data     (fifo_dout),
    .push_last     (burst_end),
    .pop           (hs),
    .set_head_last (tmr_exp),
    .head_data     (head_data),
    .head_last     (head_last),
    .cnt           (cnt)
  );
endmodule
